// File: rtl/mcpu_regfile_seq.sv
// Register file with a small command sequencer: single-cycle loads, moves
// and add-immediate, plus a two-cycle SWAP and a multi-cycle CLEAR_ALL.
// Reads are combinational with no write bypass.
module mcpu_regfile_seq #(
  parameter int WORD_SIZE        = 8,
  parameter int OPERAND_SIZE     = 3,
  parameter int REGISTERS_NUMBER = 2 ** OPERAND_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPERAND_SIZE-1:0] op1,
  input  logic [OPERAND_SIZE-1:0] op2,
  input  logic [OPERAND_SIZE-1:0] op3,
  input  logic [WORD_SIZE-1:0]    datatoload,
  input  logic                    regsetwb,
  input  logic [2:0]              regsetcmd,
  output logic [WORD_SIZE-1:0]    RegOp1,
  output logic [WORD_SIZE-1:0]    alu1,
  output logic [WORD_SIZE-1:0]    alu2,
  output logic                    busy,
  output logic                    cmd_err
);

  typedef enum logic [2:0] {
    CMD_NORMAL_EX      = 3'd0,
    CMD_LOAD_FROM_DATA = 3'd1,
    CMD_MOV_INTERNAL   = 3'd2,
    CMD_SWAP           = 3'd3,
    CMD_CLEAR_ALL      = 3'd4,
    CMD_ADD_IMM        = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP2 = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // One extra bit so the limit itself is representable when the array is full.
  localparam logic [OPERAND_SIZE:0]   REG_LIMIT = (OPERAND_SIZE + 1)'(REGISTERS_NUMBER);
  localparam logic [OPERAND_SIZE-1:0] CLR_LAST  = OPERAND_SIZE'(REGISTERS_NUMBER - 1);

  logic [WORD_SIZE-1:0]    regs [REGISTERS_NUMBER];
  state_e                  state_q, state_d;
  logic [WORD_SIZE-1:0]    tmp_q;
  logic [OPERAND_SIZE-1:0] swap_op1_q;
  logic [OPERAND_SIZE-1:0] clr_cnt_q;
  logic                    cmd_err_q;

  logic                    wr_en;
  logic [OPERAND_SIZE-1:0] wr_idx;
  logic [WORD_SIZE-1:0]    wr_data;
  logic                    latch_swap;
  logic                    err_d;
  logic                    ok1, ok2, ok3;

  assign ok1 = {1'b0, op1} < REG_LIMIT;
  assign ok2 = {1'b0, op2} < REG_LIMIT;
  assign ok3 = {1'b0, op3} < REG_LIMIT;

  // Combinational read ports; indices past the populated range read as zero.
  assign RegOp1 = ok1 ? regs[op1] : '0;
  assign alu1   = ok2 ? regs[op2] : '0;
  assign alu2   = ok3 ? regs[op3] : '0;

  assign busy    = (state_q != ST_IDLE);
  assign cmd_err = cmd_err_q;

  // Next-state decode and the single register write port.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;
    latch_swap = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (regsetwb) begin
          case (regsetcmd)
            CMD_NORMAL_EX, CMD_LOAD_FROM_DATA: begin
              if (ok1) begin
                wr_en   = 1'b1;
                wr_idx  = op1;
                wr_data = datatoload;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_MOV_INTERNAL: begin
              if (ok1 && ok2) begin
                wr_en   = 1'b1;
                wr_idx  = op1;
                wr_data = alu1;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_ADD_IMM: begin
              if (ok1 && ok2) begin
                wr_en   = 1'b1;
                wr_idx  = op1;
                wr_data = alu1 + datatoload;  // carry out is dropped
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_SWAP: begin
              // First half: reg[op2] takes reg[op1]; old reg[op2] parks in tmp.
              if (ok1 && ok2) begin
                wr_en      = 1'b1;
                wr_idx     = op2;
                wr_data    = RegOp1;
                latch_swap = 1'b1;
                state_d    = ST_SWAP2;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_CLEAR_ALL: state_d = ST_CLEAR;
            default:       err_d   = 1'b1;
          endcase
        end
      end
      ST_SWAP2: begin
        wr_en   = 1'b1;
        wr_idx  = swap_op1_q;
        wr_data = tmp_q;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = clr_cnt_q;
        wr_data = '0;
        if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, swap scratch, clear counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmp_q      <= '0;
      swap_op1_q <= '0;
      clr_cnt_q  <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= err_d;
      if (latch_swap) begin
        tmp_q      <= alu1;
        swap_op1_q <= op1;
      end
      if (state_q == ST_CLEAR) begin
        clr_cnt_q <= (clr_cnt_q == CLR_LAST) ? '0 : clr_cnt_q + 1'b1;
      end
    end
  end

  // Register array storage with its single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is built from flops, not RAM, because reset must clear
    // every entry at once without waiting for the clock.
    if (!rst_n) begin
      for (int i = 0; i < REGISTERS_NUMBER; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

endmodule
